rv32v_scalar_issue_bridge: RTL and testbench
============================================

Name: rv32v_scalar_issue_bridge

Overview:
Scalar-core end of the scalar-to-vector link.
- Queues vector instructions with their scalar operands (instr, rs1_data, rs2_data) from scalar decode and presents them to the vector unit.
- Forwards the if-return and exception-return signals to the vector unit.
- Merges vector scalar-destination writebacks (rd_wen, rd_sel, rd_data) into the scalar register-file write port.
- Keeps a pending-register scoreboard so the scalar pipeline stalls on RAW/WAW hazards against outstanding vector results.

Parameters:
QDEPTH, 4, issue FIFO entries (power of two, >=2)
WBDEPTH, 2, vector writeback buffer entries (power of two, >=1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
issue_valid  in  1  decode presents a vector instruction
issue_instr  in  32  instruction word
issue_rs1_data  in  32  scalar operand 1
issue_rs2_data  in  32  scalar operand 2
issue_writes_rd  in  1  instruction returns a scalar result
issue_rd_sel  in  5  scalar destination
issue_ready  out  1  bridge accepts this cycle
instr  out  32  head instruction to vector unit
rs1_data  out  32  head operand 1
rs2_data  out  32  head operand 2
v_valid  out  1  head valid
v_ready  in  1  vector unit takes head
scalar_hazard_if_ret  out  1  registered copy of if_ret_in
returnex  out  1  one-cycle flush pulse to vector unit
if_ret_in  in  1  scalar hazard unit if-return
flush  in  1  scalar pipeline flush/exception return
rd_wen  in  1  vector scalar writeback valid
rd_sel  in  5  vector writeback register
rd_data  in  32  vector writeback data
scalar_wb_wen  in  1  scalar pipeline writeback (priority)
scalar_wb_sel  in  5  scalar writeback register
scalar_wb_data  in  32  scalar writeback data
rf_wen  out  1  register-file write enable
rf_sel  out  5  register-file write address
rf_data  out  32  register-file write data
hz_rs1_sel, hz_rs2_sel, hz_rd_sel  in  5 each  decode register selects to check
hazard_stall  out  1  selected register has a pending vector write
wb_overflow  out  1  sticky error

Behaviour:
Reset:
- All outputs 0; FIFOs empty; scoreboard clear; wb_overflow cleared only by RST.

Issue FIFO:
- issue_ready = !full && !(issue_writes_rd && rd!=0 && pending[issue_rd_sel]) && !flush.
- Enqueue on issue_valid&&issue_ready.
- v_valid = !empty; outputs show head entry; dequeue on v_valid&&v_ready.
- Enqueue and dequeue may occur in the same cycle when not full. ready is low when full, even with a concurrent dequeue.
- Latency: enqueue at cycle N gives v_valid at N+1.
- Pointers wrap modulo QDEPTH.

Scoreboard:
- 32 pending bits.
- Set pending[rd] on enqueue when writes_rd && rd!=0.
- Cleared when that register's vector result is written to the RF.
- Same-register set/clear in one cycle cannot occur, because ready blocks a second writer to a pending register.
- hazard_stall = OR of pending[hz_*] with x0 ignored; combinational from registered state.

Flush:
- Drops all undispatched FIFO entries and clears their pending bits.
- Entries already dispatched stay pending.
- returnex pulses at N+1.
- An enqueue in the flush cycle is blocked.

Writeback merge:
- rd_wen with rd_sel!=0 pushes to the WB buffer; rd_sel==0 is dropped.
- rf_* are registered.
- If scalar_wb_wen: rf_* = scalar writeback, and the buffer holds.
- Otherwise, if the buffer is non-empty: pop to rf_* and clear the pending bit.
- A push and a pop in the same cycle are allowed.
- A push when full (with no pop that cycle) discards the data and sets wb_overflow.

Optional Feature:
RV32V_BRIDGE_PERF_EN
- Defined: adds outputs perf_issued (32, counts dequeues) and perf_stall (32, counts cycles with issue_valid && !issue_ready). Both wrap and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- rv32v_types_pkg holds:
  - typedef vissue_entry_t {instr, rs1_data, rs2_data, writes_rd, rd_sel}
  - typedef vwb_entry_t {sel, data}
  - QDEPTH/WBDEPTH defaults
- Sub-module rv32v_sync_fifo, a parameterized type/depth FIFO that also exposes its entries for the flush-clear scan. Instantiated for both the issue queue and the WB buffer.

Test Plan:
- Enqueue instr 0x0200_7057, rs1=5, rd=10, v_ready=1 -> v_valid at next cycle; pending[10]=1; hz_rs1_sel=10 gives hazard_stall=1.
- v_ready=0, 4 enqueues -> issue_ready=0 after 4th; a 5th is held; raising v_ready dequeues in order.
- rd_wen rd_sel=10 data 0xDEAD_BEEF with scalar_wb_wen=1 (sel 3) -> rf writes x3 first, x10=0xDEADBEEF next cycle; pending[10] clears.
- Second enqueue to pending rd 10 -> issue_ready=0 until the x10 writeback commits.
- flush with 2 queued entries (rd 6, 7) -> v_valid=0 next cycle; pending[6,7]=0; returnex pulses one cycle.
- 3 rd_wen pushes under continuous scalar_wb_wen with WBDEPTH=2 -> wb_overflow=1 and stays set until RST.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared types and defaults for the scalar-to-vector issue bridge.
package rv32v_types_pkg;

    localparam int QDEPTH_DEF  = 4;
    localparam int WBDEPTH_DEF = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        writes_rd;
        logic [4:0]  rd_sel;
    } vissue_entry_t;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } vwb_entry_t;

    // One-hot register mask; x0 never appears in the scoreboard.
    function automatic logic [31:0] reg_mask(input logic [4:0] sel);
        logic [31:0] m;
        m = '0;
        if (sel != 5'd0) m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rv32v_sync_fifo.sv
// Type/depth-parameterized synchronous FIFO with a combinational head and an
// entry scan port that reports which entries survive this cycle's dequeue.
module rv32v_sync_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  T                 wdata,
    output T                 head,
    output logic             full,
    output logic             empty,
    output T [DEPTH-1:0]     entries,
    output logic [DEPTH-1:0] entry_pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem_reg [DEPTH];
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (!do_push && do_pop) count_reg <= count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_reg[wr_ptr_reg] <= wdata;
    end

    // An entry is live if its distance from the head is below the count; the
    // head being dequeued this cycle counts as already dispatched.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_scan
        logic [CW-1:0] offset;
        assign offset            = CW'((gi + DEPTH - int'(rd_ptr_reg)) % DEPTH);
        assign entries[gi]       = mem_reg[gi];
        assign entry_pending[gi] = (offset < count_reg) && !(do_pop && offset == '0);
    end

endmodule

// File: rtl/rv32v_scalar_issue_bridge.sv
// Scalar side of the scalar-to-vector link: issue queue, writeback merge and
// pending-register scoreboard. Define RV32V_BRIDGE_PERF_EN for perf counters.
module rv32v_scalar_issue_bridge
    import rv32v_types_pkg::*;
#(
    parameter int QDEPTH  = QDEPTH_DEF,
    parameter int WBDEPTH = WBDEPTH_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        issue_valid,
    input  logic [31:0] issue_instr,
    input  logic [31:0] issue_rs1_data,
    input  logic [31:0] issue_rs2_data,
    input  logic        issue_writes_rd,
    input  logic [4:0]  issue_rd_sel,
    output logic        issue_ready,
    output logic [31:0] instr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        v_valid,
    input  logic        v_ready,
    output logic        scalar_hazard_if_ret,
    output logic        returnex,
    input  logic        if_ret_in,
    input  logic        flush,
    input  logic        rd_wen,
    input  logic [4:0]  rd_sel,
    input  logic [31:0] rd_data,
    input  logic        scalar_wb_wen,
    input  logic [4:0]  scalar_wb_sel,
    input  logic [31:0] scalar_wb_data,
    output logic        rf_wen,
    output logic [4:0]  rf_sel,
    output logic [31:0] rf_data,
    input  logic [4:0]  hz_rs1_sel,
    input  logic [4:0]  hz_rs2_sel,
    input  logic [4:0]  hz_rd_sel,
    output logic        hazard_stall,
    output logic        wb_overflow
`ifdef RV32V_BRIDGE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    vissue_entry_t                issue_entry, iq_head;
    vissue_entry_t [QDEPTH-1:0]   iq_entries;
    logic [QDEPTH-1:0]            iq_kept;
    logic                         iq_full, iq_empty, issue_fire, v_fire;
    vwb_entry_t                   wb_entry, wb_head;
    vwb_entry_t [WBDEPTH-1:0]     wb_entries_unused;
    logic [WBDEPTH-1:0]           wb_kept_unused;
    logic                         wb_full, wb_empty, wb_push, wb_pop, wb_accept;
    logic                         head_meta_unused;
    logic [31:0]                  pending_reg, pending_next, drop_mask;
    logic                         returnex_reg, if_ret_reg, overflow_reg;
    logic                         rf_wen_reg;
    logic [4:0]                   rf_sel_reg;
    logic [31:0]                  rf_data_reg;

    assign issue_entry = '{instr: issue_instr, rs1_data: issue_rs1_data,
                           rs2_data: issue_rs2_data, writes_rd: issue_writes_rd,
                           rd_sel: issue_rd_sel};

    // A second writer to a pending register is held back, so set and clear
    // of the same scoreboard bit never collide.
    assign issue_ready = !RST && !iq_full && !flush &&
                         !(issue_writes_rd && |(reg_mask(issue_rd_sel) & pending_reg));
    assign issue_fire  = issue_valid && issue_ready;
    assign v_valid     = !RST && !iq_empty;
    assign v_fire      = v_valid && v_ready;
    assign instr       = v_valid ? iq_head.instr    : '0;
    assign rs1_data    = v_valid ? iq_head.rs1_data : '0;
    assign rs2_data    = v_valid ? iq_head.rs2_data : '0;
    assign head_meta_unused = ^{iq_head.writes_rd, iq_head.rd_sel};

    rv32v_sync_fifo #(.T(vissue_entry_t), .DEPTH(QDEPTH)) u_issue_fifo (
        .clk(CLK), .srst(RST), .clear(flush), .push(issue_fire), .pop(v_fire),
        .wdata(issue_entry), .head(iq_head), .full(iq_full), .empty(iq_empty),
        .entries(iq_entries), .entry_pending(iq_kept)
    );

    assign wb_entry  = '{sel: rd_sel, data: rd_data};
    assign wb_push   = rd_wen && (rd_sel != 5'd0);
    assign wb_pop    = !scalar_wb_wen && !wb_empty;
    assign wb_accept = wb_push && (!wb_full || wb_pop);

    rv32v_sync_fifo #(.T(vwb_entry_t), .DEPTH(WBDEPTH)) u_wb_fifo (
        .clk(CLK), .srst(RST), .clear(1'b0), .push(wb_accept), .pop(wb_pop),
        .wdata(wb_entry), .head(wb_head), .full(wb_full), .empty(wb_empty),
        .entries(wb_entries_unused), .entry_pending(wb_kept_unused)
    );

    always_comb begin
        drop_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (iq_kept[i] && iq_entries[i].writes_rd)
                drop_mask = drop_mask | reg_mask(iq_entries[i].rd_sel);
        end
    end

    always_comb begin
        pending_next = pending_reg;
        if (flush)  pending_next = pending_next & ~drop_mask;
        if (wb_pop) pending_next = pending_next & ~reg_mask(wb_head.sel);
        if (issue_fire && issue_writes_rd)
            pending_next = pending_next | reg_mask(issue_rd_sel);
    end

    assign hazard_stall = |(pending_reg & (reg_mask(hz_rs1_sel) | reg_mask(hz_rs2_sel) |
                                           reg_mask(hz_rd_sel)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_reg  <= '0;
            returnex_reg <= 1'b0;
            if_ret_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            rf_wen_reg   <= 1'b0;
            rf_sel_reg   <= '0;
            rf_data_reg  <= '0;
        end else begin
            pending_reg  <= pending_next;
            returnex_reg <= flush;
            if_ret_reg   <= if_ret_in;
            if (wb_push && !wb_accept) overflow_reg <= 1'b1;
            // Scalar pipeline owns the port when it writes; the buffer waits.
            rf_wen_reg <= scalar_wb_wen || wb_pop;
            if (scalar_wb_wen) begin
                rf_sel_reg  <= scalar_wb_sel;
                rf_data_reg <= scalar_wb_data;
            end else if (wb_pop) begin
                rf_sel_reg  <= wb_head.sel;
                rf_data_reg <= wb_head.data;
            end
        end
    end

    assign returnex             = returnex_reg;
    assign scalar_hazard_if_ret = if_ret_reg;
    assign wb_overflow          = overflow_reg;
    assign rf_wen               = rf_wen_reg;
    assign rf_sel               = rf_sel_reg;
    assign rf_data              = rf_data_reg;

`ifdef RV32V_BRIDGE_PERF_EN
    logic [31:0] perf_issued_reg, perf_stall_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_issued_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            if (v_fire) perf_issued_reg <= perf_issued_reg + 32'd1;
            if (issue_valid && !issue_ready) perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_issued = perf_issued_reg;
    assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_rv32v_scalar_issue_bridge.sv
// Bench for rv32v_scalar_issue_bridge: directed table, hand sequences for
// full-queue and writeback overflow, then random traffic against a queue model.
module tb_rv32v_scalar_issue_bridge;
    import rv32v_types_pkg::*;

    localparam int QD  = 4;
    localparam int WBD = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid, issue_writes_rd, issue_ready;
    logic [31:0] issue_instr, issue_rs1_data, issue_rs2_data;
    logic [4:0]  issue_rd_sel;
    logic [31:0] instr, rs1_data, rs2_data;
    logic        v_valid, v_ready, scalar_hazard_if_ret, returnex, if_ret_in, flush;
    logic        rd_wen, scalar_wb_wen, rf_wen, hazard_stall, wb_overflow;
    logic [4:0]  rd_sel, scalar_wb_sel, rf_sel, hz_rs1_sel, hz_rs2_sel, hz_rd_sel;
    logic [31:0] rd_data, scalar_wb_data, rf_data;
`ifdef RV32V_BRIDGE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    rv32v_scalar_issue_bridge #(.QDEPTH(QD), .WBDEPTH(WBD)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_writes_rd(issue_writes_rd), .issue_rd_sel(issue_rd_sel),
        .issue_ready(issue_ready), .instr(instr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .v_valid(v_valid), .v_ready(v_ready),
        .scalar_hazard_if_ret(scalar_hazard_if_ret), .returnex(returnex),
        .if_ret_in(if_ret_in), .flush(flush), .rd_wen(rd_wen), .rd_sel(rd_sel),
        .rd_data(rd_data), .scalar_wb_wen(scalar_wb_wen),
        .scalar_wb_sel(scalar_wb_sel), .scalar_wb_data(scalar_wb_data),
        .rf_wen(rf_wen), .rf_sel(rf_sel), .rf_data(rf_data),
        .hz_rs1_sel(hz_rs1_sel), .hz_rs2_sel(hz_rs2_sel), .hz_rd_sel(hz_rd_sel),
        .hazard_stall(hazard_stall),
`ifdef RV32V_BRIDGE_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .wb_overflow(wb_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        issue_valid = 0; issue_instr = 0; issue_rs1_data = 0; issue_rs2_data = 0;
        issue_writes_rd = 0; issue_rd_sel = 0; v_ready = 0; if_ret_in = 0; flush = 0;
        rd_wen = 0; rd_sel = 0; rd_data = 0; scalar_wb_wen = 0; scalar_wb_sel = 0;
        scalar_wb_data = 0; hz_rs1_sel = 0; hz_rs2_sel = 0; hz_rd_sel = 0;
    endtask

    task automatic do_reset();
        set_idle();
        hz_rs1_sel = 10;
        RST = 1;
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_v_valid", v_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_returnex", returnex, 0);
        chk("rst_wb_overflow", wb_overflow, 0);
        chk("rst_hazard", hazard_stall, 0);
        @(negedge CLK);
        RST = 0;
        hz_rs1_sel = 0;
        $display("reset applied");
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] iv, ins, wrd, rd, vr, fl, rdw, rds, rdd, sw, ss, sd, h1;
        logic [31:0] e_rdy, e_vv, e_ins, e_hz, e_rfw, e_rfs, e_rfd, e_rx;
    } vec_t;

    task automatic run_row(input int idx, input vec_t r);
        issue_valid = r.iv[0]; issue_instr = r.ins; issue_rs1_data = 32'd5;
        issue_rs2_data = 32'd0; issue_writes_rd = r.wrd[0]; issue_rd_sel = r.rd[4:0];
        v_ready = r.vr[0]; flush = r.fl[0]; rd_wen = r.rdw[0]; rd_sel = r.rds[4:0];
        rd_data = r.rdd; scalar_wb_wen = r.sw[0]; scalar_wb_sel = r.ss[4:0];
        scalar_wb_data = r.sd; hz_rs1_sel = r.h1[4:0];
        #1;
        chk($sformatf("row%0d_issue_ready", idx), issue_ready, r.e_rdy);
        chk($sformatf("row%0d_v_valid", idx), v_valid, r.e_vv);
        chk($sformatf("row%0d_instr", idx), instr, r.e_ins);
        chk($sformatf("row%0d_hazard", idx), hazard_stall, r.e_hz);
        @(posedge CLK); #1;
        chk($sformatf("row%0d_rf_wen", idx), rf_wen, r.e_rfw);
        if (r.e_rfw[0]) begin
            chk($sformatf("row%0d_rf_sel", idx), rf_sel, r.e_rfs);
            chk($sformatf("row%0d_rf_data", idx), rf_data, r.e_rfd);
        end
        chk($sformatf("row%0d_returnex", idx), returnex, r.e_rx);
        $display("row %0d: iv=%0d instr=%h rd=%0d ready=%0d v_valid=%0d hz=%0d rf_wen=%0d",
                 idx, r.iv, r.ins, r.rd, issue_ready, v_valid, hazard_stall, rf_wen);
        @(negedge CLK);
    endtask

    task automatic run_table();
        vec_t tbl[14];
        //         iv ins           wrd rd vr fl rdw rds rdd           sw ss sd     h1  rdy vv ins           hz rfw rfs rfd           rx
        tbl[0]  = '{1, 32'h02007057, 1, 10, 1, 0, 0, 0,  0,            0, 0, 0,     10, 1, 0, 0,            0, 0, 0,  0,            0};
        tbl[1]  = '{0, 0,            0, 0,  1, 0, 0, 0,  0,            0, 0, 0,     10, 1, 1, 32'h02007057, 1, 0, 0,  0,            0};
        tbl[2]  = '{0, 0,            0, 0,  1, 0, 0, 0,  0,            0, 0, 0,     10, 1, 0, 0,            1, 0, 0,  0,            0};
        tbl[3]  = '{1, 32'h11111111, 1, 10, 0, 0, 0, 0,  0,            0, 0, 0,     10, 0, 0, 0,            1, 0, 0,  0,            0};
        tbl[4]  = '{1, 32'h11111111, 1, 10, 0, 0, 1, 10, 32'hDEADBEEF, 1, 3, 32'h33, 10, 0, 0, 0,            1, 1, 3,  32'h33,       0};
        tbl[5]  = '{1, 32'h11111111, 1, 10, 0, 0, 0, 0,  0,            0, 0, 0,     10, 0, 0, 0,            1, 1, 10, 32'hDEADBEEF, 0};
        tbl[6]  = '{1, 32'h11111111, 1, 10, 0, 0, 0, 0,  0,            0, 0, 0,     10, 1, 0, 0,            0, 0, 0,  0,            0};
        tbl[7]  = '{1, 32'h22222222, 1, 6,  1, 0, 0, 0,  0,            0, 0, 0,     6,  1, 1, 32'h11111111, 0, 0, 0,  0,            0};
        tbl[8]  = '{1, 32'h33333333, 1, 7,  0, 0, 0, 0,  0,            0, 0, 0,     6,  1, 1, 32'h22222222, 1, 0, 0,  0,            0};
        tbl[9]  = '{1, 32'h44444444, 1, 8,  0, 1, 0, 0,  0,            0, 0, 0,     7,  0, 1, 32'h22222222, 1, 0, 0,  0,            1};
        tbl[10] = '{0, 0,            0, 0,  0, 0, 0, 0,  0,            0, 0, 0,     6,  1, 0, 0,            0, 0, 0,  0,            0};
        tbl[11] = '{0, 0,            0, 0,  0, 0, 0, 0,  0,            0, 0, 0,     10, 1, 0, 0,            1, 0, 0,  0,            0};
        tbl[12] = '{0, 0,            0, 0,  0, 0, 0, 0,  0,            0, 0, 0,     7,  1, 0, 0,            0, 0, 0,  0,            0};
        tbl[13] = '{0, 0,            0, 0,  0, 0, 0, 0,  0,            0, 0, 0,     8,  1, 0, 0,            0, 0, 0,  0,            0};
        for (int i = 0; i < 14; i++) run_row(i, tbl[i]);
        set_idle();
    endtask

    // Fill the queue with v_ready low, hold a fifth, then drain in order.
    task automatic run_full_queue();
        logic [31:0] exp_ins [5];
        int got;
        for (int k = 0; k < 5; k++) exp_ins[k] = 32'hA0000001 + k;
        set_idle();
        for (int k = 0; k < 4; k++) begin
            issue_valid = 1; issue_instr = exp_ins[k];
            #1 chk($sformatf("fill%0d_ready", k), issue_ready, 1);
            $display("fill: enqueue %h", exp_ins[k]);
            @(posedge CLK); @(negedge CLK);
        end
        issue_instr = exp_ins[4];
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("full_ready", issue_ready, 0);
            chk("full_v_valid", v_valid, 1);
            chk("full_head", instr, exp_ins[0]);
            $display("full: fifth instruction held");
            @(posedge CLK); @(negedge CLK);
        end
        got = 0;
        for (int c = 0; c < 12; c++) begin
            v_ready = 1;
            issue_valid = (c < 2);
            #1;
            if (c == 0) chk("full_pop_ready", issue_ready, 0);
            if (c == 1) chk("after_pop_ready", issue_ready, 1);
            if (v_valid) begin
                if (got < 5) chk($sformatf("drain%0d_instr", got), instr, exp_ins[got]);
                $display("drain: dequeue %h", instr);
                got++;
            end
            @(posedge CLK); @(negedge CLK);
        end
        chk("drain_count", got, 5);
        set_idle();
    endtask

    // WB buffer overflow under continuous scalar writeback, then drain.
    task automatic run_overflow();
        logic [31:0] sw_a [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [31:0] rw_a [7] = '{1, 1, 1, 0, 0, 0, 0};
        logic [31:0] ov_a [7] = '{0, 0, 1, 1, 1, 1, 1};
        logic [31:0] rs_a [7] = '{1, 1, 1, 1, 11, 12, 0};
        logic [31:0] we_a [7] = '{1, 1, 1, 1, 1, 1, 0};
        set_idle();
        for (int c = 0; c < 7; c++) begin
            scalar_wb_wen = sw_a[c][0]; scalar_wb_sel = 5'd1; scalar_wb_data = 32'h5CA10001;
            rd_wen = rw_a[c][0]; rd_sel = 5'(11 + c); rd_data = 32'h10000000 + 11 + c;
            @(posedge CLK); #1;
            chk($sformatf("ovf%0d_flag", c), wb_overflow, ov_a[c]);
            chk($sformatf("ovf%0d_rf_wen", c), rf_wen, we_a[c]);
            if (we_a[c][0]) begin
                chk($sformatf("ovf%0d_rf_sel", c), rf_sel, rs_a[c]);
                chk($sformatf("ovf%0d_rf_data", c), rf_data,
                    (rs_a[c] == 1) ? 32'h5CA10001 : 32'h10000000 + rs_a[c]);
            end
            $display("wb cycle %0d: rf_wen=%0d rf_sel=%0d overflow=%0d", c, rf_wen, rf_sel, wb_overflow);
            @(negedge CLK);
        end
        set_idle();
    endtask

    // ---------------- random traffic vs. queue model ----------------
    vissue_entry_t mq[$];
    vwb_entry_t    mwb[$];
    bit            mpend[32];
    bit            movf;

    function automatic bit pend_hit(input logic [4:0] r);
        return (r != 5'd0) && mpend[r];
    endfunction

    task automatic run_random(input int cycles);
        bit e_rdy, e_vv, e_hz, e_rfw;
        logic [4:0] e_rfs;
        logic [31:0] e_rfd;
        mq.delete(); mwb.delete(); movf = 0;
        for (int r = 0; r < 32; r++) mpend[r] = 0;
        for (int c = 0; c < cycles; c++) begin
            issue_valid = ($urandom_range(0, 9) < 6); issue_instr = $urandom;
            issue_rs1_data = $urandom; issue_rs2_data = $urandom;
            issue_writes_rd = 1'($urandom_range(0, 1)); issue_rd_sel = 5'($urandom_range(0, 7));
            v_ready = 1'($urandom_range(0, 1)); flush = ($urandom_range(0, 19) == 0);
            if_ret_in = 1'($urandom_range(0, 1));
            rd_wen = ($urandom_range(0, 9) < 3); rd_sel = 5'($urandom_range(0, 7)); rd_data = $urandom;
            scalar_wb_wen = ($urandom_range(0, 9) < 4); scalar_wb_sel = 5'($urandom_range(0, 31));
            scalar_wb_data = $urandom;
            hz_rs1_sel = 5'($urandom_range(0, 7)); hz_rs2_sel = 5'($urandom_range(0, 7));
            hz_rd_sel = 5'($urandom_range(0, 7));
            #1;
            e_rdy = (mq.size() < QD) && !flush && !(issue_writes_rd && pend_hit(issue_rd_sel));
            e_vv  = (mq.size() > 0);
            e_hz  = pend_hit(hz_rs1_sel) || pend_hit(hz_rs2_sel) || pend_hit(hz_rd_sel);
            chk("rnd_issue_ready", issue_ready, e_rdy);
            chk("rnd_v_valid", v_valid, e_vv);
            chk("rnd_hazard", hazard_stall, e_hz);
            if (e_vv) begin
                chk("rnd_instr", instr, mq[0].instr);
                chk("rnd_rs1", rs1_data, mq[0].rs1_data);
                chk("rnd_rs2", rs2_data, mq[0].rs2_data);
            end
            @(posedge CLK);
            e_rfw = 0; e_rfs = 0; e_rfd = 0;
            if (scalar_wb_wen) begin
                e_rfw = 1; e_rfs = scalar_wb_sel; e_rfd = scalar_wb_data;
            end else if (mwb.size() > 0) begin
                e_rfw = 1; e_rfs = mwb[0].sel; e_rfd = mwb[0].data;
                mpend[mwb[0].sel] = 0;
                void'(mwb.pop_front());
            end
            if (rd_wen && rd_sel != 0) begin
                if (mwb.size() < WBD) mwb.push_back('{sel: rd_sel, data: rd_data});
                else movf = 1;
            end
            if (e_vv && v_ready) begin
                $display("rnd dispatch: instr=%h rd=%0d", mq[0].instr, mq[0].rd_sel);
                void'(mq.pop_front());
            end
            if (flush) begin
                foreach (mq[i]) if (mq[i].writes_rd) mpend[mq[i].rd_sel] = 0;
                mq.delete();
            end
            if (issue_valid && e_rdy) begin
                mq.push_back('{instr: issue_instr, rs1_data: issue_rs1_data,
                               rs2_data: issue_rs2_data, writes_rd: issue_writes_rd,
                               rd_sel: issue_rd_sel});
                if (issue_writes_rd && issue_rd_sel != 0) mpend[issue_rd_sel] = 1;
            end
            #1;
            chk("rnd_rf_wen", rf_wen, e_rfw);
            if (e_rfw) begin
                chk("rnd_rf_sel", rf_sel, e_rfs);
                chk("rnd_rf_data", rf_data, e_rfd);
            end
            chk("rnd_returnex", returnex, flush);
            chk("rnd_if_ret", scalar_hazard_if_ret, if_ret_in);
            chk("rnd_overflow", wb_overflow, movf);
            @(negedge CLK);
        end
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set_idle();
        RST = 1;
        do_reset();
        run_table();
        run_full_queue();
        run_overflow();
        do_reset();
        run_random(600);
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
